// File: rtl/pifo_dequeue_ctrl.sv
// Purpose: consumer-side dequeue engine for a register PIFO, with optional rank-as-timestamp shaping and a drain/discard flush FSM.
// Latency: pifo_remove is combinational from the PIFO head; a removed entry appears on m_valid/m_rank/m_meta the following cycle.
// Backpressure: a 2-entry output buffer absorbs m_ready stalls; removes stop when it is full, and m_ready never reaches pifo_remove combinationally.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   en, shaping_en            dequeue enable; shaping (release when rank <= now, serial-number compare)
//   time_tick                 advance the internal time counter by one
//   flush                     drain and discard the PIFO and output buffer
//   pifo_valid/rank/meta      current PIFO head (combinational view)
//   pifo_remove               single-cycle pop of the PIFO head
//   m_valid/m_ready/m_rank/m_meta  downstream valid/ready stream
//   now                       current time counter
//   busy, flush_done          flush in progress; one-cycle pulse when flush completes
//   deq_count, drop_count     downstream handshakes (wraps); flushed PIFO entries (saturates)

module pifo_dequeue_ctrl #(
    parameter int RANK_W = 16,
    parameter int META_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              shaping_en,
    input  logic              time_tick,
    input  logic              flush,
    input  logic              pifo_valid,
    input  logic [RANK_W-1:0] pifo_rank,
    input  logic [META_W-1:0] pifo_meta,
    output logic              pifo_remove,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [RANK_W-1:0] m_rank,
    output logic [META_W-1:0] m_meta,
    output logic [RANK_W-1:0] now,
    output logic              busy,
    output logic              flush_done,
    output logic [CNT_W-1:0]  deq_count,
    output logic [CNT_W-1:0]  drop_count
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Output buffer: head register drives the stream directly, tail holds the
    // second entry while the head is stalled.
    logic [1:0]        buf_count_q;
    logic [1:0]        buf_count_d;
    logic [RANK_W-1:0] head_rank_q;
    logic [RANK_W-1:0] head_rank_d;
    logic [META_W-1:0] head_meta_q;
    logic [META_W-1:0] head_meta_d;
    logic [RANK_W-1:0] tail_rank_q;
    logic [RANK_W-1:0] tail_rank_d;
    logic [META_W-1:0] tail_meta_q;
    logic [META_W-1:0] tail_meta_d;

    logic [RANK_W-1:0] now_q;
    logic              flush_done_q;
    logic              flush_done_d;
    logic [CNT_W-1:0]  deq_count_q;
    logic [CNT_W-1:0]  drop_count_q;

    logic [RANK_W-1:0] rank_diff;
    logic              eligible;
    logic              xfer;
    logic              remove;
    logic              drop;

    // Serial-number compare: the head is due when (rank - now) is zero or
    // negative in two's complement, which stays correct across counter wrap
    // as long as the distance is below half the rank space.
    assign rank_diff = pifo_rank - now_q;
    assign eligible  = ~shaping_en | (rank_diff == '0) | rank_diff[RANK_W-1];

    assign xfer = (buf_count_q != 2'd0) & m_ready;

    // ------------------------------------------------------------------
    // Next-state, remove and buffer control
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        remove       = 1'b0;
        drop         = 1'b0;
        flush_done_d = 1'b0;
        buf_count_d  = buf_count_q;
        head_rank_d  = head_rank_q;
        head_meta_d  = head_meta_q;
        tail_rank_d  = tail_rank_q;
        tail_meta_d  = tail_meta_q;

        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    // A transfer in this cycle still completes (counted via
                    // xfer); whatever is left in the buffer is discarded.
                    state_d     = ST_FLUSH;
                    buf_count_d = 2'd0;
                end else begin
                    // Full buffer blocks the remove; a pop this cycle does not
                    // reopen it, keeping m_ready out of the remove path.
                    remove = en & pifo_valid & eligible & (buf_count_q != 2'd2);
                    case (buf_count_q)
                        2'd0: begin
                            if (remove) begin
                                head_rank_d = pifo_rank;
                                head_meta_d = pifo_meta;
                                buf_count_d = 2'd1;
                            end
                        end
                        2'd1: begin
                            if (remove && xfer) begin
                                head_rank_d = pifo_rank;
                                head_meta_d = pifo_meta;
                            end else if (remove) begin
                                tail_rank_d = pifo_rank;
                                tail_meta_d = pifo_meta;
                                buf_count_d = 2'd2;
                            end else if (xfer) begin
                                buf_count_d = 2'd0;
                            end
                        end
                        default: begin
                            if (xfer) begin
                                head_rank_d = tail_rank_q;
                                head_meta_d = tail_meta_q;
                                buf_count_d = 2'd1;
                            end
                        end
                    endcase
                end
            end

            ST_FLUSH: begin
                // Pop everything regardless of en/eligibility; nothing is
                // buffered. The first empty head ends the flush.
                remove = pifo_valid;
                drop   = pifo_valid;
                if (!pifo_valid) begin
                    state_d      = ST_RUN;
                    flush_done_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_RUN;
                buf_count_d = 2'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= flush_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_count_q <= 2'd0;
            head_rank_q <= '0;
            head_meta_q <= '0;
            tail_rank_q <= '0;
            tail_meta_q <= '0;
        end else begin
            buf_count_q <= buf_count_d;
            head_rank_q <= head_rank_d;
            head_meta_q <= head_meta_d;
            tail_rank_q <= tail_rank_d;
            tail_meta_q <= tail_meta_d;
        end
    end

    // ------------------------------------------------------------------
    // Time base and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            now_q        <= '0;
            deq_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            if (time_tick) begin
                now_q <= now_q + RANK_W'(1);
            end
            if (xfer) begin
                deq_count_q <= deq_count_q + CNT_W'(1);
            end
            if (drop && (drop_count_q != '1)) begin
                drop_count_q <= drop_count_q + CNT_W'(1);
            end
        end
    end

    // No pops while reset is asserted, so the PIFO is never disturbed by an
    // engine whose state is being reinitialised.
    assign pifo_remove = remove & ~rst;

    assign m_valid    = (buf_count_q != 2'd0);
    assign m_rank     = head_rank_q;
    assign m_meta     = head_meta_q;
    assign now        = now_q;
    assign busy       = (state_q == ST_FLUSH);
    assign flush_done = flush_done_q;
    assign deq_count  = deq_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_pifo_dequeue_ctrl.sv
// Directed bench for pifo_dequeue_ctrl: a behavioural PIFO (sorted queue)
// feeds the head, and a scoreboard of expected {rank, meta} is consumed on
// every downstream handshake.

module tb_pifo_dequeue_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        shaping_en;
    logic        time_tick;
    logic        flush;
    logic        pifo_valid;
    logic [15:0] pifo_rank;
    logic [11:0] pifo_meta;
    logic        pifo_remove;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_rank;
    logic [11:0] m_meta;
    logic [15:0] now;
    logic        busy;
    logic        flush_done;
    logic [15:0] deq_count;
    logic [15:0] drop_count;

    pifo_dequeue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .shaping_en  (shaping_en),
        .time_tick   (time_tick),
        .flush       (flush),
        .pifo_valid  (pifo_valid),
        .pifo_rank   (pifo_rank),
        .pifo_meta   (pifo_meta),
        .pifo_remove (pifo_remove),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_rank      (m_rank),
        .m_meta      (m_meta),
        .now         (now),
        .busy        (busy),
        .flush_done  (flush_done),
        .deq_count   (deq_count),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    logic        last_rm;
    logic [15:0] pq_rank[$];
    logic [11:0] pq_meta[$];
    logic [27:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pifo_drive();
        pifo_valid = (pq_rank.size() != 0);
        pifo_rank  = (pq_rank.size() != 0) ? pq_rank[0] : 16'd0;
        pifo_meta  = (pq_meta.size() != 0) ? pq_meta[0] : 12'd0;
    endtask

    // Sorted insert: smallest rank at the head, ties keep arrival order.
    task automatic pifo_load(input logic [15:0] r, input logic [11:0] m);
        int  pos;
        logic found;
        pos   = pq_rank.size();
        found = 1'b0;
        for (int i = 0; i < pq_rank.size(); i++) begin
            if (!found && pq_rank[i] > r) begin
                pos   = i;
                found = 1'b1;
            end
        end
        pq_rank.insert(pos, r);
        pq_meta.insert(pos, m);
        pifo_drive();
    endtask

    task automatic load_exp(input logic [15:0] r, input logic [11:0] m);
        pifo_load(r, m);
        exp_q.push_back({r, m});
    endtask

    // One clock: called at a negedge with inputs applied. Samples the
    // combinational remove and any handshake, then advances the PIFO model.
    task automatic tick();
        logic [27:0] e;
        #1;
        last_rm = pifo_remove;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL sb_unexpected observed=%0h expected=none", {m_rank, m_meta});
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_data", 32'({m_rank, m_meta}), 32'(e));
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (last_rm === 1'b1 && pq_rank.size() != 0) begin
            void'(pq_rank.pop_front());
            void'(pq_meta.pop_front());
        end
        pifo_drive();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        last_rm     = 1'b0;
        rst         = 1'b1;
        en          = 1'b1;
        shaping_en  = 1'b0;
        time_tick   = 1'b1;
        flush       = 1'b1;
        m_ready     = 1'b1;
        pifo_drive();
        @(negedge clk);

        // ---------------- reset ----------------
        tick();
        tick();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_rank", 32'(m_rank), 32'd0);
        chk("rst_m_meta", 32'(m_meta), 32'd0);
        chk("rst_now", 32'(now), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        chk("rst_deq", 32'(deq_count), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        rst       = 1'b0;
        time_tick = 1'b0;
        flush     = 1'b0;

        // ---------------- work-conserving ----------------
        load_exp(16'd5, 12'h105);
        load_exp(16'd9, 12'h109);
        load_exp(16'd12, 12'h10C);
        tick();
        chk("wc_rm0", 32'(last_rm), 32'd1);
        chk("wc_rank0", 32'(m_rank), 32'd5);
        tick();
        chk("wc_rm1", 32'(last_rm), 32'd1);
        chk("wc_rank1", 32'(m_rank), 32'd9);
        tick();
        chk("wc_rm2", 32'(last_rm), 32'd1);
        chk("wc_rank2", 32'(m_rank), 32'd12);
        tick();
        chk("wc_rm_idle", 32'(last_rm), 32'd0);
        chk("wc_deq", 32'(deq_count), 32'd3);
        chk("wc_m_valid", 32'(m_valid), 32'd0);

        // ---------------- backpressure ----------------
        m_ready = 1'b0;
        load_exp(16'd20, 12'h200);
        load_exp(16'd21, 12'h201);
        load_exp(16'd22, 12'h202);
        load_exp(16'd23, 12'h203);
        tick();
        chk("bp_rm0", 32'(last_rm), 32'd1);
        tick();
        chk("bp_rm1", 32'(last_rm), 32'd1);
        tick();
        chk("bp_rm_full0", 32'(last_rm), 32'd0);
        tick();
        chk("bp_rm_full1", 32'(last_rm), 32'd0);
        chk("bp_hold_rank", 32'(m_rank), 32'd20);
        chk("bp_hold_meta", 32'(m_meta), 32'h200);
        m_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("bp_drained", 32'(exp_q.size()), 32'd0);
        chk("bp_pifo_empty", 32'(pq_rank.size()), 32'd0);
        chk("bp_deq", 32'(deq_count), 32'd7);

        // ---------------- shaping ----------------
        shaping_en = 1'b1;
        chk("sh_now0", 32'(now), 32'd0);
        load_exp(16'd3, 12'h033);
        tick();
        chk("sh_hold0", 32'(last_rm), 32'd0);
        tick();
        chk("sh_hold1", 32'(last_rm), 32'd0);
        time_tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sh_wait", 32'(last_rm), 32'd0);
        end
        chk("sh_now3", 32'(now), 32'd3);
        tick();
        chk("sh_release", 32'(last_rm), 32'd1);
        time_tick = 1'b0;
        tick();

        time_tick = 1'b1;
        for (int i = 0; i < 70000 && now !== 16'hFFFE; i++) tick();
        time_tick = 1'b0;
        chk("sh_now_fffe", 32'(now), 32'hFFFE);
        load_exp(16'h0001, 12'h0A1);
        time_tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sh_wrap_wait", 32'(last_rm), 32'd0);
        end
        chk("sh_now_wrapped", 32'(now), 32'h0001);
        tick();
        chk("sh_wrap_release", 32'(last_rm), 32'd1);
        time_tick = 1'b0;
        tick();
        chk("sh_now2", 32'(now), 32'd2);
        load_exp(16'hFFF0, 12'h0F0);
        tick();
        chk("sh_past_release", 32'(last_rm), 32'd1);
        tick();
        chk("sh_drained", 32'(exp_q.size()), 32'd0);
        chk("sh_deq", 32'(deq_count), 32'd10);
        shaping_en = 1'b0;

        // ---------------- flush ----------------
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) pifo_load(16'(40 + i), 12'(12'h400 + i));
        tick();
        tick();
        tick();
        chk("fl_full_rm", 32'(last_rm), 32'd0);
        chk("fl_pifo_left", 32'(pq_rank.size()), 32'd4);
        flush = 1'b1;
        tick();
        chk("fl_req_rm", 32'(last_rm), 32'd0);
        flush = 1'b0;
        chk("fl_m_valid", 32'(m_valid), 32'd0);
        chk("fl_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fl_drain_rm", 32'(last_rm), 32'd1);
            chk("fl_m_valid_hold", 32'(m_valid), 32'd0);
        end
        chk("fl_busy_mid", 32'(busy), 32'd1);
        chk("fl_drop", 32'(drop_count), 32'd4);
        tick();
        chk("fl_end_rm", 32'(last_rm), 32'd0);
        chk("fl_done_pulse", 32'(flush_done), 32'd1);
        chk("fl_busy_end", 32'(busy), 32'd0);
        tick();
        chk("fl_done_clear", 32'(flush_done), 32'd0);
        m_ready = 1'b1;
        load_exp(16'd50, 12'h500);
        tick();
        chk("fl_resume_rm", 32'(last_rm), 32'd1);
        tick();
        chk("fl_resume_deq", 32'(deq_count), 32'd11);

        // ---------------- flush with concurrent transfer ----------------
        m_ready = 1'b0;
        load_exp(16'd60, 12'h600);
        pifo_load(16'd61, 12'h601);
        pifo_load(16'd62, 12'h602);
        tick();
        tick();
        chk("sim_now_pre", 32'(now), 32'd2);
        flush     = 1'b1;
        m_ready   = 1'b1;
        time_tick = 1'b1;
        tick();
        chk("sim_rm", 32'(last_rm), 32'd0);
        flush = 1'b0;
        chk("sim_deq", 32'(deq_count), 32'd12);
        chk("sim_m_valid", 32'(m_valid), 32'd0);
        chk("sim_busy", 32'(busy), 32'd1);
        tick();
        chk("sim_drop_rm", 32'(last_rm), 32'd1);
        tick();
        time_tick = 1'b0;
        chk("sim_now_adv", 32'(now), 32'd5);
        chk("sim_drop", 32'(drop_count), 32'd5);
        chk("sim_done", 32'(flush_done), 32'd1);
        chk("sim_sb_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- reset during flush, en=0 ----------------
        m_ready = 1'b0;
        pifo_load(16'd70, 12'h700);
        pifo_load(16'd71, 12'h701);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("rf_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        en  = 1'b0;
        tick();
        chk("rf_rst_rm", 32'(last_rm), 32'd0);
        chk("rf_busy_clr", 32'(busy), 32'd0);
        chk("rf_no_done0", 32'(flush_done), 32'd0);
        rst = 1'b0;
        tick();
        chk("rf_en0_rm", 32'(last_rm), 32'd0);
        chk("rf_no_done1", 32'(flush_done), 32'd0);
        chk("rf_drop", 32'(drop_count), 32'd0);
        chk("rf_now", 32'(now), 32'd0);
        chk("rf_m_valid", 32'(m_valid), 32'd0);
        exp_q.push_back({16'd70, 12'h700});
        exp_q.push_back({16'd71, 12'h701});
        en      = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("rf_drained", 32'(exp_q.size()), 32'd0);
        chk("rf_deq", 32'(deq_count), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
